parking_slot_allocator: RTL and testbench

PARKING_SLOT_ALLOCATOR -- requirements
Module: parking_slot_allocator

---
 rtl/parking_slot_allocator.sv | 139 +++++++++++++
 tb/tb_parking_slot_allocator.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_slot_allocator.sv
// Eight-slot parking allocator: request/ack handshake with a priority search over free slots,
// departure strobes with legality checking. Define PARKING_STATS_EN to add entry/reject counters.
module parking_slot_allocator #(
  parameter int unsigned LOWEST_FIRST = 1
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       arrive_req,
  output logic       arrive_ack,
  output logic       arrive_nack,
  output logic [7:0] park_location,
  input  logic       leave_req,
  input  logic [7:0] leave_location,
  output logic [7:0] parking_capacity,
  output logic [3:0] free_count,
  output logic       full,
  output logic       empty,
  output logic       leave_error
`ifdef PARKING_STATS_EN
  ,
  output logic [15:0] total_entries,
  output logic [15:0] total_rejects
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StGrant,
    StReject,
    StWaitDrop
  } state_e;

  state_e     state_q;
  logic [7:0] cap_q, cap_d;
  logic [7:0] park_q;
  logic [7:0] pick;
  logic [7:0] free_slots;
  logic [7:0] leave_clr;
  logic [3:0] free_count_q;
  logic       ack_q, nack_q, full_q, empty_q, leave_error_q;
  logic       leave_legal;

  function automatic logic [3:0] ones(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Later loop iterations overwrite earlier ones, so the loop direction sets the priority.
  always_comb begin
    free_slots = ~cap_q;
    pick       = '0;
    if (LOWEST_FIRST != 0) begin
      for (int i = 7; i >= 0; i--) if (free_slots[i]) pick = 8'(1) << i;
    end else begin
      for (int i = 0; i < 8; i++) if (free_slots[i]) pick = 8'(1) << i;
    end
  end

  // park_q is non-zero only in GRANT, so OR-ing it in applies the grant on the GRANT edge.
  always_comb begin
    leave_legal = leave_req && $onehot(leave_location) && ((leave_location & cap_q) != 8'h00);
    leave_clr   = leave_legal ? leave_location : 8'h00;
    cap_d       = (cap_q | park_q) & ~leave_clr;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q       <= StIdle;
      cap_q         <= 8'h00;
      free_count_q  <= 4'd8;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      ack_q         <= 1'b0;
      nack_q        <= 1'b0;
      park_q        <= 8'h00;
      leave_error_q <= 1'b0;
    end else begin
      cap_q         <= cap_d;
      free_count_q  <= 4'd8 - ones(cap_d);
      full_q        <= &cap_d;
      empty_q       <= ~|cap_d;
      leave_error_q <= leave_req & ~leave_legal;
      ack_q         <= 1'b0;
      nack_q        <= 1'b0;
      park_q        <= 8'h00;
      unique case (state_q)
        StIdle: begin
          if (arrive_req) state_q <= StSearch;
        end
        StSearch: begin
          if (pick != 8'h00) begin
            state_q <= StGrant;
            ack_q   <= 1'b1;
            park_q  <= pick;
          end else begin
            state_q <= StReject;
            nack_q  <= 1'b1;
          end
        end
        StGrant:  state_q <= StWaitDrop;
        StReject: state_q <= StWaitDrop;
        StWaitDrop: begin
          if (!arrive_req) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PARKING_STATS_EN
  logic [15:0] entries_q, rejects_q;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      entries_q <= 16'h0000;
      rejects_q <= 16'h0000;
    end else begin
      if (state_q == StGrant)  entries_q <= entries_q + 16'd1;
      if (state_q == StReject) rejects_q <= rejects_q + 16'd1;
    end
  end

  assign total_entries = entries_q;
  assign total_rejects = rejects_q;
`endif

  assign arrive_ack       = ack_q;
  assign arrive_nack      = nack_q;
  assign park_location    = park_q;
  assign parking_capacity = cap_q;
  assign free_count       = free_count_q;
  assign full             = full_q;
  assign empty            = empty_q;
  assign leave_error      = leave_error_q;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Bench for parking_slot_allocator: two instances (lowest-first and highest-first) share stimulus
// and are checked cycle by cycle against a transaction-level occupancy model.
module tb_parking_slot_allocator;

  logic       clock, nreset, arrive_req, leave_req;
  logic [7:0] leave_location;
  logic       ack [2];
  logic       nack [2];
  logic       lerr [2];
  logic       full_o [2];
  logic       empty_o [2];
  logic [7:0] park [2];
  logic [7:0] cap [2];
  logic [3:0] fc [2];
`ifdef PARKING_STATS_EN
  logic [15:0] ent [2];
  logic [15:0] rej [2];
  logic [15:0] m_ent [2];
  logic [15:0] m_rej [2];
`endif

  logic [7:0] m_cap [2];
  logic [7:0] m_park [2];
  int n_checks = 0;
  int n_pass = 0;

  parking_slot_allocator #(.LOWEST_FIRST(1)) u_low (
    .clock(clock), .nreset(nreset), .arrive_req(arrive_req), .arrive_ack(ack[0]),
    .arrive_nack(nack[0]), .park_location(park[0]), .leave_req(leave_req),
    .leave_location(leave_location), .parking_capacity(cap[0]), .free_count(fc[0]),
    .full(full_o[0]), .empty(empty_o[0]), .leave_error(lerr[0])
`ifdef PARKING_STATS_EN
    , .total_entries(ent[0]), .total_rejects(rej[0])
`endif
  );

  parking_slot_allocator #(.LOWEST_FIRST(0)) u_high (
    .clock(clock), .nreset(nreset), .arrive_req(arrive_req), .arrive_ack(ack[1]),
    .arrive_nack(nack[1]), .park_location(park[1]), .leave_req(leave_req),
    .leave_location(leave_location), .parking_capacity(cap[1]), .free_count(fc[1]),
    .full(full_o[1]), .empty(empty_o[1]), .leave_error(lerr[1])
`ifdef PARKING_STATS_EN
    , .total_entries(ent[1]), .total_rejects(rej[1])
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Lowest free slot via two's-complement isolate; highest via a downward scan.
  function automatic logic [7:0] pick_slot(input logic [7:0] c, input bit lowest);
    logic [7:0] f, r;
    f = ~c;
    if (f == 8'h00) return 8'h00;
    if (lowest) return f & (~f + 8'd1);
    r = 8'h80;
    while ((r & f) == 8'h00) r = r >> 1;
    return r;
  endfunction

  function automatic logic [7:0] rand_loc();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return 8'h01 << $urandom_range(0, 7);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cap[d] = 8'h00;
      m_park[d] = 8'h00;
`ifdef PARKING_STATS_EN
      m_ent[d] = 16'h0;
      m_rej[d] = 16'h0;
`endif
    end
  endtask

  task automatic do_reset();
    arrive_req = 1'b0;
    leave_req = 1'b0;
    leave_location = 8'h00;
    nreset = 1'b0;
    @(posedge clock);
    #1;
    nreset = 1'b1;
    model_reset();
  endtask

  // One clock cycle: srch marks the SEARCH cycle, grnt the GRANT/REJECT cycle of a request.
  task automatic clk_cycle(input logic req, input logic lv, input logic [7:0] loc,
                           input logic srch, input logic grnt);
    logic [7:0] nxt [2];
    logic       err [2];
    logic       legal, e_ack, e_nack;
    logic [7:0] e_park;
    arrive_req = req;
    leave_req = lv;
    leave_location = loc;
    for (int d = 0; d < 2; d++) begin
      if (srch) m_park[d] = pick_slot(m_cap[d], d == 0);
      e_ack = grnt && (m_park[d] != 8'h00);
      e_nack = grnt && (m_park[d] == 8'h00);
      e_park = e_ack ? m_park[d] : 8'h00;
      n_checks++;
      if (ack[d] !== e_ack) $display("FAIL ack dut%0d: got %b want %b", d, ack[d], e_ack);
      else n_pass++;
      n_checks++;
      if (nack[d] !== e_nack) $display("FAIL nack dut%0d: got %b want %b", d, nack[d], e_nack);
      else n_pass++;
      n_checks++;
      if (park[d] !== e_park) $display("FAIL park dut%0d: got %h want %h", d, park[d], e_park);
      else n_pass++;
      legal = lv && ($countones(loc) == 1) && ((m_cap[d] & loc) != 8'h00);
      err[d] = lv && !legal;
      nxt[d] = (m_cap[d] | e_park) & ~(legal ? loc : 8'h00);
`ifdef PARKING_STATS_EN
      if (e_ack) m_ent[d] = m_ent[d] + 16'd1;
      if (e_nack) m_rej[d] = m_rej[d] + 16'd1;
`endif
    end
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_cap[d] = nxt[d];
      n_checks++;
      if (cap[d] !== m_cap[d]) $display("FAIL cap dut%0d: got %h want %h", d, cap[d], m_cap[d]);
      else n_pass++;
      n_checks++;
      if (fc[d] !== 4'(8 - $countones(m_cap[d])))
        $display("FAIL free_count dut%0d: got %0d want %0d", d, fc[d], 8 - $countones(m_cap[d]));
      else n_pass++;
      n_checks++;
      if (full_o[d] !== (m_cap[d] == 8'hFF))
        $display("FAIL full dut%0d: got %b want %b", d, full_o[d], m_cap[d] == 8'hFF);
      else n_pass++;
      n_checks++;
      if (empty_o[d] !== (m_cap[d] == 8'h00))
        $display("FAIL empty dut%0d: got %b want %b", d, empty_o[d], m_cap[d] == 8'h00);
      else n_pass++;
      n_checks++;
      if (lerr[d] !== err[d]) $display("FAIL leave_error dut%0d: got %b want %b", d, lerr[d], err[d]);
      else n_pass++;
`ifdef PARKING_STATS_EN
      n_checks++;
      if (ent[d] !== m_ent[d] || rej[d] !== m_rej[d])
        $display("FAIL stats dut%0d: got %0d/%0d want %0d/%0d", d, ent[d], rej[d], m_ent[d], m_rej[d]);
      else n_pass++;
`endif
    end
  endtask

  // Full request: IDLE sample, SEARCH, GRANT/REJECT, then drop in WAIT_DROP.
  task automatic run_txn(input logic [3:0] en, input logic [31:0] locs);
    clk_cycle(1'b1, en[0], locs[7:0], 1'b0, 1'b0);
    clk_cycle(1'b1, en[1], locs[15:8], 1'b1, 1'b0);
    clk_cycle(1'b1, en[2], locs[23:16], 1'b0, 1'b1);
    clk_cycle(1'b0, en[3], locs[31:24], 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    arrive_req = 1'b0;
    leave_req = 1'b0;
    leave_location = 8'h00;
    #3;
    nreset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cap[d] !== 8'h00 || fc[d] !== 4'd8 || empty_o[d] !== 1'b1 || full_o[d] !== 1'b0)
        $display("FAIL reset_status dut%0d: got cap=%h fc=%0d e=%b f=%b want cap=00 fc=8 e=1 f=0",
                 d, cap[d], fc[d], empty_o[d], full_o[d]);
      else n_pass++;
      n_checks++;
      if (ack[d] !== 1'b0 || nack[d] !== 1'b0 || lerr[d] !== 1'b0 || park[d] !== 8'h00)
        $display("FAIL reset_pulses dut%0d: got ack=%b nack=%b err=%b park=%h want all 0",
                 d, ack[d], nack[d], lerr[d], park[d]);
      else n_pass++;
`ifdef PARKING_STATS_EN
      n_checks++;
      if (ent[d] !== 16'h0 || rej[d] !== 16'h0)
        $display("FAIL reset_stats dut%0d: got %0d/%0d want 0/0", d, ent[d], rej[d]);
      else n_pass++;
`endif
    end
    @(posedge clock);
    #1;
    nreset = 1'b1;
    model_reset();
  endtask

  task automatic test_first_grant();
    run_txn(4'b0000, 32'h0);
    n_checks++;
    if (cap[0] !== 8'h01 || fc[0] !== 4'd7)
      $display("FAIL first_grant: got cap=%h fc=%0d want cap=01 fc=7", cap[0], fc[0]);
    else n_pass++;
  endtask

  task automatic test_fill_highest();
    repeat (6) run_txn(4'b0000, 32'h0);
    n_checks++;
    if (cap[1] !== 8'hFE) $display("FAIL fill_high_pre: got %h want fe", cap[1]);
    else n_pass++;
    run_txn(4'b0000, 32'h0);
    n_checks++;
    if (cap[1] !== 8'hFF || full_o[1] !== 1'b1)
      $display("FAIL fill_high_last: got cap=%h full=%b want cap=ff full=1", cap[1], full_o[1]);
    else n_pass++;
  endtask

  task automatic test_full_reject();
    run_txn(4'b0000, 32'h0);
    n_checks++;
    if (cap[0] !== 8'hFF || cap[1] !== 8'hFF)
      $display("FAIL reject_cap: got %h/%h want ff/ff", cap[0], cap[1]);
    else n_pass++;
`ifdef PARKING_STATS_EN
    n_checks++;
    if (rej[0] !== 16'd1) $display("FAIL reject_count: got %0d want 1", rej[0]);
    else n_pass++;
`endif
  endtask

  task automatic test_leave_errors();
    clk_cycle(1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
    clk_cycle(1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
    clk_cycle(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
    clk_cycle(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    clk_cycle(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    n_checks++;
    if (lerr[0] !== 1'b1 || cap[0] !== 8'h0F)
      $display("FAIL leave_free_slot: got err=%b cap=%h want err=1 cap=0f", lerr[0], cap[0]);
    else n_pass++;
    clk_cycle(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    n_checks++;
    if (lerr[0] !== 1'b1) $display("FAIL leave_multi_bit: got %b want 1", lerr[0]);
    else n_pass++;
    clk_cycle(1'b0, 1'b1, 8'h04, 1'b0, 1'b0);
    n_checks++;
    if (cap[0] !== 8'h0B || lerr[0] !== 1'b0)
      $display("FAIL leave_legal: got cap=%h err=%b want cap=0b err=0", cap[0], lerr[0]);
    else n_pass++;
    clk_cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_coincident();
    clk_cycle(1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
    clk_cycle(1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    run_txn(4'b0100, 32'h0001_0000);
    n_checks++;
    if (cap[0] !== 8'h02 || fc[0] !== 4'd7)
      $display("FAIL coincident: got cap=%h fc=%0d want cap=02 fc=7", cap[0], fc[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_search();
    do_reset();
    repeat (6) run_txn(4'b0000, 32'h0);
    clk_cycle(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    clk_cycle(1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    n_checks++;
    if (cap[0] !== 8'h3C) $display("FAIL pre_reset_cap: got %h want 3c", cap[0]);
    else n_pass++;
    clk_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    nreset = 1'b0;
    #1;
    n_checks++;
    if (cap[0] !== 8'h00 || ack[0] !== 1'b0 || nack[0] !== 1'b0 || fc[0] !== 4'd8)
      $display("FAIL mid_reset: got cap=%h ack=%b nack=%b fc=%0d want cap=00 ack=0 nack=0 fc=8",
               cap[0], ack[0], nack[0], fc[0]);
    else n_pass++;
    #2;
    nreset = 1'b1;
    model_reset();
    run_txn(4'b0000, 32'h0);
    n_checks++;
    if (cap[0] !== 8'h01) $display("FAIL post_reset_grant: got %h want 01", cap[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] locs;
    for (int n = 0; n < 60; n++) begin
      locs = {rand_loc(), rand_loc(), rand_loc(), rand_loc()};
      run_txn(4'($urandom_range(0, 15)), locs);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        clk_cycle(1'b0, 1'($urandom_range(0, 1)), rand_loc(), 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_fill_highest();
    test_full_reject();
    test_leave_errors();
    test_coincident();
    test_reset_mid_search();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
